// File: rtl/rx_buf_ctrl.sv
// FIFO controller for the receiver's single-port byte RAM: writes from the UART
// always take the shared address; reads run a 3-state issue/capture sequence.
module rx_buf_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rd_req,
  input  logic                  clr_ovf,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_acc, drop, cap;

  // full/empty come straight from the registered count, so a slot freed by
  // CAPTURE only becomes writable on the following cycle.
  assign full   = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty  = (count == '0);
  assign wr_acc = rx_valid & ~full;
  assign drop   = rx_valid & full;
  assign cap    = (state == CAPTURE);

  assign ram_we   = wr_acc;
  assign ram_data = rx_data;
  assign ram_addr = wr_acc ? wr_ptr : rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;

      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (wr_acc && !cap)      count <= count + 1'b1;
      else if (!wr_acc && cap) count <= count - 1'b1;

      case (state)
        IDLE:    if (rd_req && !empty) state <= ISSUE;
        // A write owns the port this cycle; retry the read address next cycle.
        ISSUE:   if (!wr_acc) state <= CAPTURE;
        CAPTURE: begin
          dout       <= ram_q;
          dout_valid <= 1'b1;
          rd_ptr     <= rd_ptr + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_buf_ctrl.sv
// Bench for rx_buf_ctrl: behavioural single-port RAM, per-cycle vector table,
// hand sequences for contention/wrap/reset, and a byte scoreboard on dout.
module tb_rx_buf_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, rd_req, clr_ovf;
  logic [7:0] dout, ram_data, ram_q;
  logic       dout_valid, empty, full, overflow, ram_we;
  logic [2:0] count;
  logic [1:0] ram_addr;

  rx_buf_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_req(rd_req), .clr_ovf(clr_ovf), .dout(dout), .dout_valid(dout_valid),
    .count(count), .empty(empty), .full(full), .overflow(overflow),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM: registered address, read-before-write output.
  logic [7:0] mem [4];
  initial for (int i = 0; i < 4; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];
  logic       we_s;
  logic [1:0] addr_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every dout pulse must deliver the oldest byte still owed to the consumer.
  always @(negedge clk) begin
    if (dout_valid) begin
      if (sb.size() == 0) chk("unexpected_dout_valid", 32'(dout_valid), 32'd0);
      else chk("dout_order", 32'(dout), 32'(sb.pop_front()));
    end
  end

  // One clock cycle: drive inputs, sample the RAM port mid-cycle, return 1ns after the edge.
  task automatic cyc1(input logic rv, input logic [7:0] d, input logic rr, input logic co);
    rx_valid = rv; rx_data = d; rd_req = rr; clr_ovf = co;
    @(negedge clk);
    we_s = ram_we; addr_s = ram_addr;
    @(posedge clk); #1;
    rx_valid = 1'b0; rd_req = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc1(1'b1, d, 1'b0, 1'b0);
    chk("wr_we", 32'(we_s), 32'd1);
    sb.push_back(d);
  endtask

  task automatic read_one(input int exp_lat);
    int n = 0;
    do begin
      cyc1(1'b0, 8'h00, n == 0, 1'b0);
      n++;
    end while (!dout_valid && n < 10);
    chk("read_latency", 32'(n), 32'(exp_lat));
  endtask

  typedef struct packed {
    logic       rv;
    logic [7:0] d;
    logic       rr, co, we;
    logic [2:0] cnt;
    logic       fl, em, ov, dv;
  } vec_t;
  vec_t vecs[$];

  initial begin
    rst = 1'b1; rx_valid = 0; rx_data = 0; rd_req = 0; clr_ovf = 0;
    //                rv   d     rr co we  cnt  fl em ov dv
    vecs.push_back(vec_t'{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int r = 0; r < 3; r++) begin
      vecs.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'(3-r), 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'(3-r), 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'(2-r), 1'b0, r == 2, 1'b0, 1'b1});
    end
    for (int i = 0; i < 4; i++)
      vecs.push_back(vec_t'{1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1, 3'(i+1), i == 3, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_dout", {23'd0, dout_valid, dout}, 32'd0);

    // Basic FIFO, 3-cycle latency, fill, drop while full, clear of sticky flag.
    foreach (vecs[i]) begin
      cyc1(vecs[i].rv, vecs[i].d, vecs[i].rr, vecs[i].co);
      if (vecs[i].rv && vecs[i].we) sb.push_back(vecs[i].d);
      chk($sformatf("v%0d_we", i), 32'(we_s), 32'(vecs[i].we));
      chk($sformatf("v%0d_cnt", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_flags", i), {29'd0, full, empty, overflow},
          {29'd0, vecs[i].fl, vecs[i].em, vecs[i].ov});
      chk($sformatf("v%0d_dv", i), 32'(dout_valid), 32'(vecs[i].dv));
    end
    for (int i = 0; i < 4; i++) read_one(3);
    chk("drain_empty", 32'(empty), 32'd1);

    // Writes during ISSUE hold off the read; pointers are both 3 here.
    wr(8'h51);
    cyc1(1'b0, 8'h00, 1'b1, 1'b0);
    cyc1(1'b1, 8'h52, 1'b0, 1'b0); sb.push_back(8'h52);
    chk("issue_we0", {30'd0, we_s, 1'b0} | 32'(addr_s), 32'h2 | 32'd0);
    cyc1(1'b1, 8'h53, 1'b0, 1'b0); sb.push_back(8'h53);
    chk("issue_we1", {30'd0, we_s, 1'b0} | 32'(addr_s), 32'h3);
    cyc1(1'b0, 8'h00, 1'b0, 1'b0);
    chk("issue_rdaddr", {30'd0, we_s, 1'b0} | 32'(addr_s), 32'h3);
    chk("issue_not_yet", 32'(dout_valid), 32'd0);
    cyc1(1'b0, 8'h00, 1'b0, 1'b0);
    chk("issue_dv_delayed", 32'(dout_valid), 32'd1);
    chk("issue_count", 32'(count), 32'd2);
    read_one(3); read_one(3);

    // Wrap: pointers start at 2 and pass 3->0 with interleaved traffic.
    wr(8'hC0); wr(8'hC1);
    for (int i = 2; i < 6; i++) begin
      wr(8'hC0 + 8'(i));
      chk("wrap_count", 32'(count), 32'd3);
      read_one(3);
    end
    read_one(3); read_one(3);
    chk("wrap_empty", 32'(count), 32'd0);

    // Full with a write arriving in the CAPTURE cycle: dropped on registered full.
    for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i));
    cyc1(1'b0, 8'h00, 1'b1, 1'b0);
    cyc1(1'b0, 8'h00, 1'b0, 1'b0);
    cyc1(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("cap_drop_we", 32'(we_s), 32'd0);
    chk("cap_drop_cnt", 32'(count), 32'd3);
    chk("cap_drop_ovf", 32'(overflow), 32'd1);
    wr(8'hE5);
    chk("cap_next_cnt", 32'(count), 32'd4);
    cyc1(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) read_one(3);

    // Reset during CAPTURE abandons the read.
    wr(8'h77); void'(sb.pop_back());
    cyc1(1'b0, 8'h00, 1'b1, 1'b0);
    cyc1(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    cyc1(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_cap_dv", 32'(dout_valid), 32'd0);
    chk("rst_cap_cnt", 32'(count), 32'd0);
    chk("rst_cap_empty", 32'(empty), 32'd1);
    cyc1(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc1(1'b0, 8'h00, 1'b0, 1'b0);
      chk("empty_rd_ignored", 32'(dout_valid), 32'd0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
